// File: rtl/backward_maccum.sv
// Backpropagation multiply-accumulate: err[p] = sum_c W[c][p]*delta[c], one column per cycle.
// Optional clamp of each result to the WF-bit range: define BACKWARD_MACCUM_SATURATE_EN.
module backward_maccum #(
    parameter int unsigned NP    = 7,
    parameter int unsigned NC    = 11,
    parameter int unsigned WF    = 5,
    parameter string       BURST = "yes"
) (
    input  logic                                 iCLK,
    input  logic                                 iRST,
    input  logic                                 iValid_AM_Weight,
    output logic                                 oReady_AM_Weight,
    input  logic [NC*NP*WF-1:0]                  iData_AM_Weight,
    input  logic                                 iValid_AM_Delta,
    output logic                                 oReady_AM_Delta,
    input  logic [NC*WF-1:0]                     iData_AM_Delta,
    output logic                                 oValid_BM_Error,
    input  logic                                 iReady_BM_Error,
    output logic [NP*($clog2(NC)+WF)-1:0]        oData_BM_Error
);

    localparam int unsigned WA       = $clog2(NC) + WF;
    localparam int unsigned CW       = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned COL_BITS = NP * WF;
    localparam bit          BURST_EN = (BURST == "yes");
`ifdef BACKWARD_MACCUM_SATURATE_EN
    localparam logic signed [WA-1:0] SAT_MAX = WA'((2 ** (WF - 1)) - 1);
    localparam logic signed [WA-1:0] SAT_MIN = WA'(-(2 ** (WF - 1)));
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           col;
    logic [NC*NP*WF-1:0]     w_q;
    logic [NC*WF-1:0]        d_q;
    logic signed [WA-1:0]    acc     [NP];
    logic signed [WA-1:0]    acc_sum [NP];
    logic signed [2*WF-1:0]  prod    [NP];
    logic signed [WF-1:0]    term    [NP];
    logic signed [WF-1:0]    d_cur;
    logic [NP*WA-1:0]        result;
    logic                    ready_c;
    logic                    both_valid;
    logic                    last_col;

    assign both_valid       = iValid_AM_Weight & iValid_AM_Delta;
    assign last_col         = (col == CW'(NC - 1));
    assign oReady_AM_Weight = ready_c;
    assign oReady_AM_Delta  = ready_c;

    // Next state and joined input handshake
    always_comb begin
        state_n = state;
        ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (both_valid) begin
                    ready_c = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (last_col) state_n = OUT;
            end
            OUT: begin
                if (iReady_BM_Error) begin
                    if (BURST_EN && both_valid) begin
                        ready_c = 1'b1;
                        state_n = ACCUM;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (iRST) ready_c = 1'b0;
    end

    // Current column always sits in the low slice; latched vectors shift down each ACCUM cycle
    always_comb begin
        d_cur  = $signed(d_q[WF-1:0]);
        result = '0;
        for (int p = 0; p < int'(NP); p++) begin
            prod[p]    = $signed(w_q[p*WF +: WF]) * d_cur;
            term[p]    = WF'(prod[p] >>> (WF - 1));
            acc_sum[p] = acc[p] + WA'(term[p]);
`ifdef BACKWARD_MACCUM_SATURATE_EN
            if (acc_sum[p] > SAT_MAX)
                result[p*WA +: WA] = SAT_MAX;
            else if (acc_sum[p] < SAT_MIN)
                result[p*WA +: WA] = SAT_MIN;
            else
                result[p*WA +: WA] = acc_sum[p];
`else
            result[p*WA +: WA] = acc_sum[p];
`endif
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state           <= IDLE;
            col             <= '0;
            w_q             <= '0;
            d_q             <= '0;
            oValid_BM_Error <= 1'b0;
            oData_BM_Error  <= '0;
            for (int p = 0; p < int'(NP); p++) acc[p] <= '0;
        end else begin
            state           <= state_n;
            oValid_BM_Error <= (state_n == OUT);
            if (ready_c) begin
                w_q <= iData_AM_Weight;
                d_q <= iData_AM_Delta;
                col <= '0;
                for (int p = 0; p < int'(NP); p++) acc[p] <= '0;
            end else if (state == ACCUM) begin
                w_q <= w_q >> COL_BITS;
                d_q <= d_q >> WF;
                col <= col + CW'(1);
                for (int p = 0; p < int'(NP); p++) acc[p] <= acc_sum[p];
                if (last_col) oData_BM_Error <= result;
            end
        end
    end

endmodule

// File: tb/tb_backward_maccum.sv
// Self-checking bench for backward_maccum against an integer reference model.
module tb_backward_maccum;

    localparam int NP = 7;
    localparam int NC = 11;
    localparam int WF = 5;
    localparam int WA = $clog2(NC) + WF;

    logic                 iCLK;
    logic                 iRST;
    logic                 iValid_AM_Weight;
    logic                 oReady_AM_Weight;
    logic [NC*NP*WF-1:0]  iData_AM_Weight;
    logic                 iValid_AM_Delta;
    logic                 oReady_AM_Delta;
    logic [NC*WF-1:0]     iData_AM_Delta;
    logic                 oValid_BM_Error;
    logic                 iReady_BM_Error;
    logic [NP*WA-1:0]     oData_BM_Error;

    int checks = 0;
    int errors = 0;
    int tw [NC][NP];
    int td [NC];

    backward_maccum #(.NP(NP), .NC(NC), .WF(WF), .BURST("yes")) dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .iValid_AM_Weight (iValid_AM_Weight),
        .oReady_AM_Weight (oReady_AM_Weight),
        .iData_AM_Weight  (iData_AM_Weight),
        .iValid_AM_Delta  (iValid_AM_Delta),
        .oReady_AM_Delta  (oReady_AM_Delta),
        .iData_AM_Delta   (iData_AM_Delta),
        .oValid_BM_Error  (oValid_BM_Error),
        .iReady_BM_Error  (iReady_BM_Error),
        .oData_BM_Error   (oData_BM_Error)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic int wrap(input int v, input int bits);
        int m;
        int r;
        m = 1 << bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: plain integer sum of truncated Q-format products
    function automatic logic [NP*WA-1:0] model();
        logic [NP*WA-1:0] r;
        int s;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            s = 0;
            for (int c = 0; c < NC; c++)
                s += wrap((tw[c][p] * td[c]) >>> (WF - 1), WF);
            s = wrap(s, WA);
`ifdef BACKWARD_MACCUM_SATURATE_EN
            if (s > (1 << (WF - 1)) - 1) s = (1 << (WF - 1)) - 1;
            if (s < -(1 << (WF - 1))) s = -(1 << (WF - 1));
`endif
            r[p*WA +: WA] = WA'(s);
        end
        return r;
    endfunction

    function automatic logic [NP*WA-1:0] splat(input int v);
        logic [NP*WA-1:0] r;
        for (int p = 0; p < NP; p++) r[p*WA +: WA] = WA'(v);
        return r;
    endfunction

    task automatic pack();
        for (int c = 0; c < NC; c++) begin
            iData_AM_Delta[c*WF +: WF] = WF'(td[c]);
            for (int p = 0; p < NP; p++)
                iData_AM_Weight[(c*NP+p)*WF +: WF] = WF'(tw[c][p]);
        end
    endtask

    task automatic rand_data();
        for (int c = 0; c < NC; c++) begin
            td[c] = int'($urandom_range(0, 31)) - 16;
            for (int p = 0; p < NP; p++) tw[c][p] = int'($urandom_range(0, 31)) - 16;
        end
        pack();
    endtask

    // Accept one vector from idle, wait for the result, consume it; lat = -1 on timeout
    task automatic do_txn(output logic [NP*WA-1:0] got, output int lat);
        @(negedge iCLK);
        pack();
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        lat = 1;
        while (!oValid_BM_Error && lat < 100) begin
            @(negedge iCLK);
            lat++;
        end
        if (!oValid_BM_Error) lat = -1;
        got = oData_BM_Error;
        iReady_BM_Error = 1'b1;
        @(negedge iCLK);
        iReady_BM_Error = 1'b0;
    endtask

    task automatic test_reset();
        logic [NP*WA-1:0] got;
        logic [NP*WA-1:0] exp;
        int lat;
        int seen;
        iRST = 1'b1;
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        iReady_BM_Error  = 1'b0;
        rand_data();
        @(negedge iCLK);
        @(negedge iCLK);
        checks++;
        if ({oValid_BM_Error, oData_BM_Error, oReady_AM_Weight, oReady_AM_Delta} !== '0) begin
            errors++;
            $display("FAIL reset_initial valid=%0b data=%h rdy=%0b%0b required all zero",
                     oValid_BM_Error, oData_BM_Error, oReady_AM_Weight, oReady_AM_Delta);
        end
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        iRST = 1'b0;

        rand_data();
        exp = model();
        do_txn(got, lat);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_pre_txn got=%h required=%h", got, exp);
        end

        // Second accept, then reset part way through accumulation
        rand_data();
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        @(posedge iCLK);
        repeat (4) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        checks++;
        if ({oValid_BM_Error, oData_BM_Error, oReady_AM_Weight, oReady_AM_Delta} !== '0) begin
            errors++;
            $display("FAIL reset_mid_accum valid=%0b data=%h rdy=%0b%0b required all zero",
                     oValid_BM_Error, oData_BM_Error, oReady_AM_Weight, oReady_AM_Delta);
        end
        @(negedge iCLK);
        iRST = 1'b0;
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        seen = 0;
        repeat (NC + 5) begin
            @(negedge iCLK);
            if (oValid_BM_Error) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_output valid_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_single_column_value();
        logic [NP*WA-1:0] got;
        int lat;
        for (int c = 0; c < NC; c++) begin
            td[c] = 8;
            for (int p = 0; p < NP; p++) tw[c][p] = 8;
        end
        do_txn(got, lat);
        checks++;
        if (got !== splat(44)) begin
            errors++;
            $display("FAIL half_times_half got=%h required=%h", got, splat(44));
        end
        checks++;
        if (lat !== NC + 1) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d", lat, NC + 1);
        end
    endtask

    task automatic test_signs_order();
        logic [NP*WA-1:0] got;
        int lat;
        for (int c = 0; c < NC; c++) begin
            td[c] = (c % 2 == 0) ? 8 : 0;
            for (int p = 0; p < NP; p++) tw[c][p] = -8;
        end
        do_txn(got, lat);
        checks++;
        if (got !== splat(-24)) begin
            errors++;
            $display("FAIL signs_even_cols got=%h required=%h", got, splat(-24));
        end
        // Weight only on column NC-1 separates column order from sum order
        for (int c = 0; c < NC; c++) begin
            td[c] = c - 5;
            for (int p = 0; p < NP; p++) tw[c][p] = (c == NC - 1) ? p - 3 : 0;
        end
        do_txn(got, lat);
        checks++;
        if (got !== model()) begin
            errors++;
            $display("FAIL column_select got=%h required=%h", got, model());
        end
    endtask

    task automatic test_random();
        logic [NP*WA-1:0] got;
        logic [NP*WA-1:0] exp;
        int lat;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            if (i == 0)
                for (int c = 0; c < NC; c++) begin
                    td[c] = -16;
                    for (int p = 0; p < NP; p++) tw[c][p] = -16;
                end
            pack();
            exp = model();
            do_txn(got, lat);
            checks++;
            if (got !== exp || lat !== NC + 1) begin
                errors++;
                $display("FAIL random_%0d got=%h lat=%0d required=%h lat=%0d", i, got, lat, exp, NC + 1);
            end
        end
    endtask

    task automatic test_joined_handshake();
        logic [NP*WA-1:0] exp;
        int lat;
        int bad;
        rand_data();
        exp = model();
        @(negedge iCLK);
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b0;
        bad = 0;
        repeat (3) begin
            #1;
            if (oReady_AM_Weight || oReady_AM_Delta) bad++;
            @(negedge iCLK);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL join_one_side ready_cycles=%0d required=0", bad);
        end
        iValid_AM_Delta = 1'b1;
        #1;
        checks++;
        if (oReady_AM_Weight !== 1'b1 || oReady_AM_Delta !== 1'b1) begin
            errors++;
            $display("FAIL join_both rdy=%0b%0b required=11", oReady_AM_Weight, oReady_AM_Delta);
        end
        @(posedge iCLK);
        @(negedge iCLK);
        rand_data();
        #1;
        checks++;
        if (oReady_AM_Weight !== 1'b0 || oReady_AM_Delta !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_accum rdy=%0b%0b required=00", oReady_AM_Weight, oReady_AM_Delta);
        end
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        lat = 1;
        while (!oValid_BM_Error && lat < 100) begin
            @(negedge iCLK);
            lat++;
        end
        checks++;
        if (oData_BM_Error !== exp || lat !== NC + 1) begin
            errors++;
            $display("FAIL join_latched got=%h lat=%0d required=%h lat=%0d", oData_BM_Error, lat, exp, NC + 1);
        end
        iReady_BM_Error = 1'b1;
        @(negedge iCLK);
        iReady_BM_Error = 1'b0;
    endtask

    task automatic test_backpressure_burst();
        logic [NP*WA-1:0] exp1;
        logic [NP*WA-1:0] exp2;
        int lat;
        int bad;
        rand_data();
        exp1 = model();
        @(negedge iCLK);
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        lat = 1;
        while (!oValid_BM_Error && lat < 100) begin
            @(negedge iCLK);
            lat++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (oValid_BM_Error !== 1'b1 || oData_BM_Error !== exp1) bad++;
            @(negedge iCLK);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d required=0 last=%h exp=%h", bad, oData_BM_Error, exp1);
        end
        rand_data();
        exp2 = model();
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        iReady_BM_Error  = 1'b1;
        #1;
        checks++;
        if (oReady_AM_Weight !== 1'b1 || oReady_AM_Delta !== 1'b1) begin
            errors++;
            $display("FAIL burst_accept rdy=%0b%0b required=11", oReady_AM_Weight, oReady_AM_Delta);
        end
        @(posedge iCLK);
        @(negedge iCLK);
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        iReady_BM_Error  = 1'b0;
        lat = 1;
        while (!oValid_BM_Error && lat < 100) begin
            @(negedge iCLK);
            lat++;
        end
        checks++;
        if (oData_BM_Error !== exp2 || lat !== NC + 1) begin
            errors++;
            $display("FAIL burst_result got=%h lat=%0d required=%h lat=%0d", oData_BM_Error, lat, exp2, NC + 1);
        end
        iReady_BM_Error = 1'b1;
        @(negedge iCLK);
        iReady_BM_Error = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [NP*WA-1:0] q[$];
        logic [NP*WA-1:0] exp;
        int last_acc;
        int n_acc;
        int cyc;
        int gap_bad;
        int data_bad;
        last_acc = -1;
        n_acc = 0;
        cyc = 0;
        gap_bad = 0;
        data_bad = 0;
        @(negedge iCLK);
        iReady_BM_Error = 1'b1;
        while ((n_acc < 4 || q.size() != 0) && cyc < 400) begin
            rand_data();
            iValid_AM_Weight = (n_acc < 4);
            iValid_AM_Delta  = (n_acc < 4);
            #1;
            if (oValid_BM_Error) begin
                exp = (q.size() != 0) ? q.pop_front() : '0;
                if (oData_BM_Error !== exp) data_bad++;
            end
            if (oReady_AM_Weight && oReady_AM_Delta) begin
                q.push_back(model());
                if (last_acc >= 0 && cyc - last_acc != NC + 1) gap_bad++;
                last_acc = cyc;
                n_acc++;
            end
            @(negedge iCLK);
            cyc++;
        end
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        iReady_BM_Error  = 1'b0;
        checks++;
        if (gap_bad !== 0 || n_acc !== 4) begin
            errors++;
            $display("FAIL throughput gap_errors=%0d accepts=%0d required 0 and 4", gap_bad, n_acc);
        end
        checks++;
        if (data_bad !== 0 || q.size() !== 0) begin
            errors++;
            $display("FAIL stream_data bad=%0d pending=%0d required 0 and 0", data_bad, q.size());
        end
    endtask

    task automatic test_saturation();
        logic [NP*WA-1:0] got;
        logic [NP*WA-1:0] exp;
        int lat;
        for (int c = 0; c < NC; c++) begin
            td[c] = 15;
            for (int p = 0; p < NP; p++) tw[c][p] = 15;
        end
`ifdef BACKWARD_MACCUM_SATURATE_EN
        exp = splat(15);
`else
        exp = splat(154);
`endif
        do_txn(got, lat);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL saturation got=%h required=%h", got, exp);
        end
    endtask

    initial begin
        iData_AM_Weight = '0;
        iData_AM_Delta  = '0;
        test_reset();
        test_single_column_value();
        test_signs_order();
        test_random();
        test_joined_handshake();
        test_backpressure_burst();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
